// File: rtl/tpu_cmd_sequencer.sv
// Command-queue sequencer driving the tpu control pins one command at a time.
// Optional perf counters are enabled with SEQ_PERF_CNT_EN.
module tpu_cmd_sequencer #(
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned LAT_PAD    = 6,
  parameter int unsigned DRAIN_IDLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic        cmd_transpose,
  input  logic [8:0]  cmd_ptr,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_rows,
  input  logic [15:0] cmd_cols,
  input  logic [3:0]  cmd_path,
  input  logic        resume,
  input  logic        vpu_valid_in,
  output logic        ub_rd_start,
  output logic        ub_rd_transpose,
  output logic [8:0]  ub_ptr_select,
  output logic [15:0] ub_rd_addr,
  output logic [15:0] ub_rd_row_size,
  output logic [15:0] ub_rd_col_size,
  output logic [3:0]  vpu_data_pathway,
  output logic        sys_switch,
  output logic        busy,
  output logic        halted
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_busy_cyc,
  output logic [31:0] perf_drain_cyc
`endif
);

  localparam int unsigned AW = $clog2(CMD_DEPTH);
  localparam int unsigned IW = $clog2(DRAIN_IDLE) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DRAIN, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_SWITCH = 3'd2,
    OP_COMPUTE = 3'd3, OP_SYNC = 3'd4, OP_HALT = 3'd5
  } op_e;

  typedef struct packed {
    logic [2:0]  op;
    logic        tr;
    logic [8:0]  ptr;
    logic [15:0] addr;
    logic [15:0] rows;
    logic [15:0] cols;
    logic [3:0]  path;
  } cmd_t;

  cmd_t           cmd_in;
  cmd_t           mem_q [CMD_DEPTH];
  cmd_t           cmd_q;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic           full, empty, push, pop;
  state_e         state_q;
  logic [17:0]    wait_q;
  logic [IW-1:0]  idle_q;

  assign cmd_in    = {cmd_op, cmd_transpose, cmd_ptr, cmd_addr, cmd_rows, cmd_cols, cmd_path};
  assign full      = (count_q == (AW+1)'(CMD_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state_q == S_IDLE) && !empty;
  assign busy      = (state_q != S_IDLE) || !empty;
  assign halted    = (state_q == S_HALT);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      cmd_q            <= '0;
      wait_q           <= '0;
      idle_q           <= '0;
      ub_rd_start      <= 1'b0;
      ub_rd_transpose  <= 1'b0;
      ub_ptr_select    <= '0;
      ub_rd_addr       <= '0;
      ub_rd_row_size   <= '0;
      ub_rd_col_size   <= '0;
      vpu_data_pathway <= '0;
      sys_switch       <= 1'b0;
    end else begin
      ub_rd_start <= 1'b0;
      sys_switch  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            cmd_q   <= mem_q[rd_ptr_q];
            state_q <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_ISSUE;
        S_ISSUE: begin
          case (cmd_q.op)
            OP_LOAD, OP_COMPUTE: begin
              ub_rd_start     <= 1'b1;
              ub_rd_transpose <= cmd_q.tr;
              ub_ptr_select   <= cmd_q.ptr;
              ub_rd_addr      <= cmd_q.addr;
              ub_rd_row_size  <= cmd_q.rows;
              ub_rd_col_size  <= cmd_q.cols;
              if (cmd_q.op == OP_COMPUTE) vpu_data_pathway <= cmd_q.path;
              wait_q  <= {2'b00, cmd_q.rows} + {2'b00, cmd_q.cols} + 18'(LAT_PAD) - 18'd1;
              state_q <= S_WAIT;
            end
            OP_SWITCH: begin
              sys_switch <= 1'b1;
              state_q    <= S_IDLE;
            end
            OP_SYNC: begin
              idle_q  <= '0;
              state_q <= S_DRAIN;
            end
            OP_HALT: state_q <= S_HALT;
            default: state_q <= S_IDLE;
          endcase
        end
        S_WAIT: begin
          // WAIT occupies wait_q cycles (at least one) counted from the issue edge.
          if (wait_q <= 18'd1) begin
            wait_q  <= '0;
            idle_q  <= '0;
            state_q <= (cmd_q.op == OP_COMPUTE) ? S_DRAIN : S_IDLE;
          end else begin
            wait_q <= wait_q - 18'd1;
          end
        end
        S_DRAIN: begin
          if (vpu_valid_in) begin
            idle_q <= '0;
          end else if (idle_q == IW'(DRAIN_IDLE - 1)) begin
            idle_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            idle_q <= idle_q + IW'(1);
          end
        end
        S_HALT: begin
          if (resume) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_busy_cyc  <= '0;
      perf_drain_cyc <= '0;
    end else begin
      if (busy && (perf_busy_cyc != '1)) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if ((state_q == S_DRAIN) && (perf_drain_cyc != '1)) perf_drain_cyc <= perf_drain_cyc + 32'd1;
    end
  end
`endif

endmodule
